// File: rtl/calc_pkg.sv
// ============================================================
// calc_pkg : shared types and constants for the ALU scheduler
// Revision 1.0
// ============================================================
`default_nettype none

package calc_pkg;

  localparam int W     = 4;
  localparam int REP_W = 2;
  localparam int NREQ  = 2;

  localparam logic TYPE_ARITH = 1'b0;
  localparam logic TYPE_LOGIC = 1'b1;

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_SUB = 2'd1;
  localparam logic [1:0] SEL_MUL = 2'd2;
  localparam logic [1:0] SEL_SHL = 2'd3;

  localparam logic [1:0] SEL_AND = 2'd0;
  localparam logic [1:0] SEL_OR  = 2'd1;
  localparam logic [1:0] SEL_NOT = 2'd2;
  localparam logic [1:0] SEL_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_scheduler_if.sv
// ============================================================
// calc_scheduler_if : command/response bundle for both requesters
// Revision 1.0
// ============================================================
`default_nettype none

interface calc_scheduler_if;

  logic [calc_pkg::NREQ-1:0]                  req_valid;
  logic [calc_pkg::NREQ-1:0]                  req_ready;
  logic [calc_pkg::NREQ*calc_pkg::W-1:0]      req_a;
  logic [calc_pkg::NREQ*calc_pkg::W-1:0]      req_b;
  logic [calc_pkg::NREQ-1:0]                  req_type;
  logic [calc_pkg::NREQ*2-1:0]                req_sel;
  logic [calc_pkg::NREQ*calc_pkg::REP_W-1:0]  req_rep;
  logic [calc_pkg::NREQ-1:0]                  rsp_valid;
  logic [calc_pkg::NREQ-1:0]                  rsp_ready;
  logic [calc_pkg::W-1:0]                     rsp_result;
  logic                                       rsp_overflow;
  logic                                       busy;

  modport master (
    output req_valid, req_a, req_b, req_type, req_sel, req_rep, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_type, req_sel, req_rep, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_overflow, busy
  );

endinterface

`default_nettype wire

// File: rtl/calc_alu.sv
// ============================================================
// calc_alu : combinational 4-bit ALU (overflow = carry of A+B)
// Revision 1.0
// ============================================================
`default_nettype none

module calc_alu
  import calc_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_type,
  input  logic [1:0]   sel,
  output logic [W-1:0] out,
  output logic         overflow
);

  logic [W:0]     sum;
  logic [2*W-1:0] prod;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign prod     = a * b;
  // The flag reports the adder carry regardless of which operation is selected.
  assign overflow = sum[W];

  always_comb begin
    out = '0;
    if (op_type == TYPE_ARITH) begin
      case (sel)
        SEL_ADD: out = sum[W-1:0];
        SEL_SUB: out = a - b;
        SEL_MUL: out = prod[W-1:0];
        SEL_SHL: out = {a[W-2:0], 1'b0};
        default: out = '0;
      endcase
    end else begin
      case (sel)
        SEL_AND: out = a & b;
        SEL_OR:  out = a | b;
        SEL_NOT: out = ~a;
        SEL_XOR: out = a ^ b;
        default: out = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================
// rr_arb2 : 2-way round-robin arbiter, combinational
// Revision 1.0
// ============================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/calc_scheduler.sv
// ============================================================
// calc_scheduler : arbitrates two requesters onto one ALU, iterates, responds
// Revision 1.0
// ============================================================
`default_nettype none

module calc_scheduler
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  calc_scheduler_if.slave  bus
);

  state_t           state;
  logic [W-1:0]     acc;
  logic [W-1:0]     b_reg;
  logic             type_reg;
  logic [1:0]       sel_reg;
  logic [REP_W-1:0] cnt;
  logic             id;
  logic             ovf;
  logic             rr_ptr;
  logic [1:0]       rsp_valid_reg;
  logic             busy_reg;

  logic [1:0]       grant;
  logic             last_served;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             type_in;
  logic [1:0]       sel_in;
  logic [REP_W-1:0] rep_in;
  logic [W-1:0]     alu_out;
  logic             alu_ovf;

  // rr_ptr names the requester that wins a tie; it resets to 0 so requester 0 goes first.
  assign last_served = ~rr_ptr;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last_served),
    .grant (grant)
  );

  assign a_in    = grant[1] ? bus.req_a[2*W-1:W]         : bus.req_a[W-1:0];
  assign b_in    = grant[1] ? bus.req_b[2*W-1:W]         : bus.req_b[W-1:0];
  assign type_in = grant[1] ? bus.req_type[1]            : bus.req_type[0];
  assign sel_in  = grant[1] ? bus.req_sel[3:2]           : bus.req_sel[1:0];
  assign rep_in  = grant[1] ? bus.req_rep[2*REP_W-1:REP_W] : bus.req_rep[REP_W-1:0];

  calc_alu u_alu (
    .a        (acc),
    .b        (b_reg),
    .op_type  (type_reg),
    .sel      (sel_reg),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  assign bus.req_ready    = (state == IDLE) ? grant : 2'b00;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_result   = acc;
  assign bus.rsp_overflow = ovf;
  assign bus.busy         = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      b_reg         <= '0;
      type_reg      <= TYPE_ARITH;
      sel_reg       <= '0;
      cnt           <= '0;
      id            <= 1'b0;
      ovf           <= 1'b0;
      rr_ptr        <= 1'b0;
      rsp_valid_reg <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            acc      <= a_in;
            b_reg    <= b_in;
            type_reg <= type_in;
            sel_reg  <= sel_in;
            cnt      <= rep_in;
            id       <= grant[1];
            ovf      <= 1'b0;
            busy_reg <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          acc <= alu_out;
          ovf <= ovf | alu_ovf;
          if (cnt == '0) begin
            rsp_valid_reg <= id ? 2'b10 : 2'b01;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[id]) begin
            rr_ptr        <= ~id;
            rsp_valid_reg <= 2'b00;
            busy_reg      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_scheduler.sv
// ============================================================
// tb_calc_scheduler : vector table, random model check and corner sequences
// Revision 1.0
// ============================================================
`default_nettype none

module tb_calc_scheduler;
  import calc_pkg::*;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       t;
    logic [1:0] s;
    logic [1:0] r;
  } cmd_t;

  typedef struct {
    int   id;
    cmd_t c;
    int   delay;
    int   exp_res;
    int   exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   last_served = 1;

  always #5 clk = ~clk;

  calc_scheduler_if bus();

  calc_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Iterated reference: acc starts at A, each pass applies the op and keeps the low 4 bits.
  function automatic logic [4:0] model(input cmd_t c);
    int acc = int'(c.a);
    int bb  = int'(c.b);
    logic ov = 1'b0;
    for (int i = 0; i <= int'(c.r); i++) begin
      if (acc + bb > 15) ov = 1'b1;
      if (c.t == 1'b0) begin
        case (c.s)
          2'd0: acc = acc + bb;
          2'd1: acc = acc - bb;
          2'd2: acc = acc * bb;
          default: acc = acc * 2;
        endcase
      end else begin
        case (c.s)
          2'd0: acc = acc & bb;
          2'd1: acc = acc | bb;
          2'd2: acc = ~acc;
          default: acc = acc ^ bb;
        endcase
      end
      acc = acc & 15;
    end
    return {ov, 4'(acc)};
  endfunction

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_type  = '0;
    bus.req_sel   = '0;
    bus.req_rep   = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic drive_cmd(input int id, input cmd_t c);
    bus.req_a[id*4 +: 4]  = c.a;
    bus.req_b[id*4 +: 4]  = c.b;
    bus.req_type[id]      = c.t;
    bus.req_sel[id*2 +: 2] = c.s;
    bus.req_rep[id*2 +: 2] = c.r;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset rsp_result", 32'(bus.rsp_result), 32'd0);
    check("reset rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
    tick();
    rst = 1'b0;
    last_served = 1;
  endtask

  // One full transaction; exp_res < 0 means take the expectation from the model.
  task automatic run(input logic [1:0] mask, input cmd_t c0, input cmd_t c1, input int delay,
                     input int exp_res, input int exp_ovf, input string tag);
    int         g;
    int         n;
    logic [1:0] gexp;
    logic [4:0] m;
    cmd_t       cw;
    int         er;
    int         eo;
    g    = (mask == 2'b11) ? ((last_served == 0) ? 1 : 0) : ((mask == 2'b10) ? 1 : 0);
    gexp = (g == 1) ? 2'b10 : 2'b01;
    cw   = (g == 1) ? c1 : c0;
    er   = exp_res;
    eo   = exp_ovf;
    if (er < 0) begin
      m  = model(cw);
      er = int'(m[3:0]);
      eo = int'(m[4]);
    end
    if (mask[0]) drive_cmd(0, c0);
    if (mask[1]) drive_cmd(1, c1);
    bus.req_valid = mask;
    #1;
    check({tag, " grant"}, 32'(bus.req_ready), 32'(gexp));
    check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    tick();
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 12) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(int'(cw.r) + 1));
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(gexp));
    check({tag, " result"}, 32'(bus.rsp_result), 32'(er));
    check({tag, " overflow"}, 32'(bus.rsp_overflow), 32'(eo));
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    for (int d = 0; d < delay; d++) begin
      bus.req_valid = 2'b11;
      bus.rsp_ready = ~gexp;
      #1;
      check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
      tick();
      check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'(gexp));
      check({tag, " hold result"}, 32'(bus.rsp_result), 32'(er));
      check({tag, " hold busy"}, 32'(bus.busy), 32'd1);
    end
    bus.req_valid = '0;
    bus.rsp_ready = gexp;
    tick();
    bus.rsp_ready = '0;
    check({tag, " rsp drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
    last_served = g;
  endtask

  vec_t vecs[12];
  cmd_t zc;
  cmd_t ca;
  cmd_t cb;
  int   gids[$];
  int   gcyc[$];

  initial begin
    zc = '{4'd0, 4'd0, 1'b0, 2'd0, 2'd0};
    vecs[0]  = '{0, '{4'd3,  4'd5,  1'b0, 2'd0, 2'd0}, 0, 8,  0};
    vecs[1]  = '{1, '{4'd1,  4'd0,  1'b0, 2'd3, 2'd3}, 0, 0,  0};
    vecs[2]  = '{0, '{4'd9,  4'd8,  1'b0, 2'd0, 2'd1}, 0, 9,  1};
    vecs[3]  = '{1, '{4'd3,  4'd5,  1'b0, 2'd1, 2'd0}, 0, 14, 0};
    vecs[4]  = '{0, '{4'd7,  4'd3,  1'b0, 2'd2, 2'd0}, 0, 5,  0};
    vecs[5]  = '{1, '{4'd12, 4'd6,  1'b1, 2'd0, 2'd0}, 0, 4,  1};
    vecs[6]  = '{0, '{4'd10, 4'd5,  1'b1, 2'd1, 2'd0}, 0, 15, 0};
    vecs[7]  = '{1, '{4'd5,  4'd0,  1'b1, 2'd2, 2'd0}, 5, 10, 0};
    vecs[8]  = '{0, '{4'd12, 4'd10, 1'b1, 2'd3, 2'd0}, 0, 6,  1};
    vecs[9]  = '{0, '{4'd2,  4'd3,  1'b0, 2'd2, 2'd2}, 2, 6,  0};
    vecs[10] = '{1, '{4'd15, 4'd1,  1'b0, 2'd1, 2'd1}, 0, 13, 1};
    vecs[11] = '{0, '{4'd5,  4'd0,  1'b1, 2'd2, 2'd1}, 1, 5,  0};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].id == 0)
        run(2'b01, vecs[i].c, zc, vecs[i].delay, vecs[i].exp_res, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      else
        run(2'b10, zc, vecs[i].c, vecs[i].delay, vecs[i].exp_res, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Both requesters hammering with instant response acceptance.
    do_reset();
    ca = '{4'd3, 4'd5, 1'b0, 2'd0, 2'd0};
    cb = '{4'd1, 4'd1, 1'b0, 2'd0, 2'd0};
    drive_cmd(0, ca);
    drive_cmd(1, cb);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        gids.push_back(bus.req_ready[1] ? 1 : 0);
        gcyc.push_back(i);
      end
      if (bus.rsp_valid == 2'b01) check("alt rsp0 result", 32'(bus.rsp_result), 32'd8);
      if (bus.rsp_valid == 2'b10) check("alt rsp1 result", 32'(bus.rsp_result), 32'd2);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    last_served = 1;
    check("alt grant count", 32'(gids.size()), 32'd4);
    for (int k = 0; k < gids.size() && k < 4; k++) begin
      check($sformatf("alt grant%0d id", k), 32'(gids[k]), 32'(k % 2));
      check($sformatf("alt grant%0d cycle", k), 32'(gcyc[k]), 32'(3 * k));
    end
    tick();

    // Reset while iterating must abort silently.
    ca = '{4'd1, 4'd0, 1'b0, 2'd3, 2'd3};
    drive_cmd(0, ca);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = '0;
    check("abort busy before", 32'(bus.busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_served = 1;
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort req_ready", 32'(bus.req_ready), 32'd0);
    check("abort rsp_result", 32'(bus.rsp_result), 32'd0);
    check("abort rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort no response", 32'(bus.rsp_valid), 32'd0);
    end

    // Randomized traffic against the model, including contended grants.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      ca = '{4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom)};
      cb = '{4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom)};
      run(mask, ca, cb, $urandom_range(0, 3), -1, -1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
